// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt stage.
package rc4_pkg;

   localparam int S_SIZE = 256;

   typedef logic [7:0] rc4_byte_t;

   localparam rc4_byte_t ASCII_LO    = 8'h61;
   localparam rc4_byte_t ASCII_HI    = 8'h7A;
   localparam rc4_byte_t ASCII_SPACE = 8'h20;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INC_I,
      ST_RD_SI_ADDR,
      ST_RD_SI_WAIT,
      ST_RD_SI_CAP,
      ST_CALC_J,
      ST_RD_SJ_ADDR,
      ST_RD_SJ_WAIT,
      ST_RD_SJ_CAP,
      ST_WR_SJ,
      ST_WR_SI,
      ST_RD_F_ADDR,
      ST_RD_F_WAIT,
      ST_RD_F_CAP,
      ST_WR_DEC,
      ST_DONE
   } rc4_state_t;

   // Plaintext accepted during key search: lowercase letters or space.
   function automatic logic is_ascii_ok(input rc4_byte_t b);
      return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SPACE);
   endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext character filter (used only when RC4_ASCII_CHECK_EN is defined).
module rc4_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic       o_ok
);

   assign o_ok = is_ascii_ok(i_byte);

endmodule

// File: rtl/rc4_decrypt_core.sv
// RC4 PRGA decrypt stage: walks S, swaps, XORs keystream with ROM ciphertext into result RAM.
// Optional early reject of non-ASCII plaintext under macro RC4_ASCII_CHECK_EN.
//
// state         | meaning
// IDLE          | wait for start_decrypt
// INC_I         | i <= i+1
// RD_SI_ADDR    | present i to S RAM
// RD_SI_WAIT    | S RAM read latency
// RD_SI_CAP     | si <= S[i]
// CALC_J        | j <= j+si
// RD_SJ_ADDR    | present j to S RAM
// RD_SJ_WAIT    | S RAM read latency
// RD_SJ_CAP     | sj <= S[j]
// WR_SJ         | S[j] <= si
// WR_SI         | S[i] <= sj
// RD_F_ADDR     | present si+sj to S RAM, k to ROM
// RD_F_WAIT     | RAM/ROM read latency
// RD_F_CAP      | f <= S[si+sj], ct <= ROM[k]
// WR_DEC        | result[k] <= f^ct, advance or finish
// DONE          | hold until start_decrypt drops
module rc4_decrypt_core
   import rc4_pkg::*;
#(
   parameter int MSG_LEN    = 32,
   parameter int MSG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_decrypt,
   input  logic [7:0]            s_q,
   output logic [7:0]            s_address,
   output logic [7:0]            s_data,
   output logic                  s_wren,
   input  logic [7:0]            rom_q,
   output logic [MSG_ADDR_W-1:0] rom_address,
   output logic [MSG_ADDR_W-1:0] dec_address,
   output logic [7:0]            dec_data,
   output logic                  dec_wren,
   output logic                  done_decrypting,
   output logic                  key_invalid
);

   localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LEN - 1);

   rc4_state_t r_state, w_state_nxt;

   rc4_byte_t r_i, r_j, r_si, r_sj, r_f, r_ct;
   rc4_byte_t w_i_nxt, w_j_nxt, w_si_nxt, w_sj_nxt, w_f_nxt, w_ct_nxt;
   logic [MSG_ADDR_W-1:0] r_k, w_k_nxt;

   rc4_byte_t r_s_address, r_s_data, r_dec_data;
   rc4_byte_t w_s_address_nxt, w_s_data_nxt, w_dec_data_nxt;
   logic      r_s_wren, r_dec_wren, r_key_invalid;
   logic      w_s_wren_nxt, w_dec_wren_nxt, w_key_invalid_nxt;
   logic [MSG_ADDR_W-1:0] r_rom_address, r_dec_address;
   logic [MSG_ADDR_W-1:0] w_rom_address_nxt, w_dec_address_nxt;

   rc4_byte_t w_plain;
   logic      w_char_ok;

   assign w_plain = r_f ^ r_ct;

`ifdef RC4_ASCII_CHECK_EN
   rc4_char_check u_char_check (
      .i_byte (w_plain),
      .o_ok   (w_char_ok)
   );
`else
   assign w_char_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_i           <= '0;
         r_j           <= '0;
         r_k           <= '0;
         r_si          <= '0;
         r_sj          <= '0;
         r_f           <= '0;
         r_ct          <= '0;
         r_s_address   <= '0;
         r_s_data      <= '0;
         r_s_wren      <= 1'b0;
         r_rom_address <= '0;
         r_dec_address <= '0;
         r_dec_data    <= '0;
         r_dec_wren    <= 1'b0;
         r_key_invalid <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_i           <= w_i_nxt;
         r_j           <= w_j_nxt;
         r_k           <= w_k_nxt;
         r_si          <= w_si_nxt;
         r_sj          <= w_sj_nxt;
         r_f           <= w_f_nxt;
         r_ct          <= w_ct_nxt;
         r_s_address   <= w_s_address_nxt;
         r_s_data      <= w_s_data_nxt;
         r_s_wren      <= w_s_wren_nxt;
         r_rom_address <= w_rom_address_nxt;
         r_dec_address <= w_dec_address_nxt;
         r_dec_data    <= w_dec_data_nxt;
         r_dec_wren    <= w_dec_wren_nxt;
         r_key_invalid <= w_key_invalid_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_i_nxt           = r_i;
      w_j_nxt           = r_j;
      w_k_nxt           = r_k;
      w_si_nxt          = r_si;
      w_sj_nxt          = r_sj;
      w_f_nxt           = r_f;
      w_ct_nxt          = r_ct;
      w_s_address_nxt   = r_s_address;
      w_s_data_nxt      = r_s_data;
      w_s_wren_nxt      = 1'b0;
      w_rom_address_nxt = r_rom_address;
      w_dec_address_nxt = r_dec_address;
      w_dec_data_nxt    = r_dec_data;
      w_dec_wren_nxt    = 1'b0;
      w_key_invalid_nxt = r_key_invalid;

      unique case (r_state)
         ST_IDLE: begin
            if (start_decrypt) begin
               w_i_nxt           = '0;
               w_j_nxt           = '0;
               w_k_nxt           = '0;
               w_key_invalid_nxt = 1'b0;
               w_state_nxt       = ST_INC_I;
            end
         end
         ST_INC_I: begin
            w_i_nxt     = r_i + 8'd1;
            w_state_nxt = ST_RD_SI_ADDR;
         end
         ST_RD_SI_ADDR: begin
            w_s_address_nxt = r_i;
            w_state_nxt     = ST_RD_SI_WAIT;
         end
         ST_RD_SI_WAIT: w_state_nxt = ST_RD_SI_CAP;
         ST_RD_SI_CAP: begin
            w_si_nxt    = s_q;
            w_state_nxt = ST_CALC_J;
         end
         ST_CALC_J: begin
            w_j_nxt     = r_j + r_si;
            w_state_nxt = ST_RD_SJ_ADDR;
         end
         ST_RD_SJ_ADDR: begin
            w_s_address_nxt = r_j;
            w_state_nxt     = ST_RD_SJ_WAIT;
         end
         ST_RD_SJ_WAIT: w_state_nxt = ST_RD_SJ_CAP;
         ST_RD_SJ_CAP: begin
            w_sj_nxt    = s_q;
            w_state_nxt = ST_WR_SJ;
         end
         // When i==j both writes land on one address with equal data.
         ST_WR_SJ: begin
            w_s_address_nxt = r_j;
            w_s_data_nxt    = r_si;
            w_s_wren_nxt    = 1'b1;
            w_state_nxt     = ST_WR_SI;
         end
         ST_WR_SI: begin
            w_s_address_nxt = r_i;
            w_s_data_nxt    = r_sj;
            w_s_wren_nxt    = 1'b1;
            w_state_nxt     = ST_RD_F_ADDR;
         end
         ST_RD_F_ADDR: begin
            w_s_address_nxt   = r_si + r_sj;
            w_rom_address_nxt = r_k;
            w_state_nxt       = ST_RD_F_WAIT;
         end
         ST_RD_F_WAIT: w_state_nxt = ST_RD_F_CAP;
         ST_RD_F_CAP: begin
            w_f_nxt     = s_q;
            w_ct_nxt    = rom_q;
            w_state_nxt = ST_WR_DEC;
         end
         ST_WR_DEC: begin
            if (!w_char_ok) begin
               w_key_invalid_nxt = 1'b1;
               w_state_nxt       = ST_DONE;
            end else begin
               w_dec_address_nxt = r_k;
               w_dec_data_nxt    = w_plain;
               w_dec_wren_nxt    = 1'b1;
               if (r_k == K_LAST) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_k_nxt     = r_k + 1'b1;
                  w_state_nxt = ST_INC_I;
               end
            end
         end
         ST_DONE: begin
            if (!start_decrypt) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign s_address       = r_s_address;
   assign s_data          = r_s_data;
   assign s_wren          = r_s_wren;
   assign rom_address     = r_rom_address;
   assign dec_address     = r_dec_address;
   assign dec_data        = r_dec_data;
   assign dec_wren        = r_dec_wren;
   assign done_decrypting = (r_state == ST_DONE);
   assign key_invalid     = r_key_invalid;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Scoreboard bench for rc4_decrypt_core with behavioural S RAM, ciphertext ROM and result RAM.
module tb_rc4_decrypt_core;

   localparam int MSG_LEN = 9;
   localparam int AW      = 5;
`ifdef RC4_ASCII_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start_decrypt;
   logic [7:0]    s_q, s_address, s_data;
   logic          s_wren;
   logic [7:0]    rom_q;
   logic [AW-1:0] rom_address, dec_address;
   logic [7:0]    dec_data;
   logic          dec_wren, done_decrypting, key_invalid;

   always #5 clk = ~clk;

   rc4_decrypt_core #(.MSG_LEN(MSG_LEN), .MSG_ADDR_W(AW)) dut (
      .clk             (clk),
      .reset           (reset),
      .start_decrypt   (start_decrypt),
      .s_q             (s_q),
      .s_address       (s_address),
      .s_data          (s_data),
      .s_wren          (s_wren),
      .rom_q           (rom_q),
      .rom_address     (rom_address),
      .dec_address     (dec_address),
      .dec_data        (dec_data),
      .dec_wren        (dec_wren),
      .done_decrypting (done_decrypting),
      .key_invalid     (key_invalid)
   );

   logic [7:0] s_mem   [256];
   logic [7:0] rom_mem [32];
   logic [7:0] dec_mem [32];

   always @(posedge clk) begin
      s_q   <= s_mem[s_address];
      rom_q <= rom_mem[rom_address];
      if (s_wren)   s_mem[s_address]     <= s_data;
      if (dec_wren) dec_mem[dec_address] <= dec_data;
   end

   int checks   = 0;
   int failures = 0;
   int s_pulses, d_pulses, overlap;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } exp_t;
   exp_t sb[$];

   logic [7:0] init_s  [256];
   logic [7:0] init_rom[32];
   logic [7:0] exp_s   [256];
   logic [7:0] exp_dec [32];
   int         exp_n;
   bit         exp_abort;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (s_wren) s_pulses++;
         if (s_wren && dec_wren) overlap++;
         if (dec_wren) begin
            d_pulses++;
            if (sb.size() == 0) begin
               check("dec_unexpected_write", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("dec_write", int'({dec_address, dec_data}), int'({e.a, e.d}));
            end
         end
      end
   end

   // Reference RC4 PRGA over init_s/init_rom, optionally with the ASCII filter.
   task automatic model(input bit chk);
      logic [7:0] s[256];
      logic [7:0] i, j, t, idx, p;
      for (int n = 0; n < 256; n++) s[n] = init_s[n];
      i = 0; j = 0; exp_n = 0; exp_abort = 0;
      for (int k = 0; k < MSG_LEN; k++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         idx = s[i] + s[j];
         p = s[idx] ^ init_rom[k];
         if (chk && !(((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20))) begin
            exp_abort = 1;
            break;
         end
         exp_dec[k] = p;
         exp_n++;
      end
      for (int n = 0; n < 256; n++) exp_s[n] = s[n];
   endtask

   task automatic ksa(input logic [23:0] key);
      logic [7:0] kb[3];
      logic [7:0] j, t;
      kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
      for (int n = 0; n < 256; n++) init_s[n] = 8'(n);
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = j + init_s[n] + kb[n % 3];
         t = init_s[n]; init_s[n] = init_s[j]; init_s[j] = t;
      end
   endtask

   task automatic prep();
      for (int n = 0; n < 256; n++) s_mem[n] <= init_s[n];
      for (int n = 0; n < 32; n++) begin
         rom_mem[n] <= init_rom[n];
         dec_mem[n] <= 8'hEE;
      end
      model(CHECK_EN);
      s_pulses = 0; d_pulses = 0; overlap = 0;
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, int'({s_address, s_data, s_wren, rom_address, dec_address, dec_data,
                        dec_wren, done_decrypting, key_invalid}), 0);
   endtask

   task automatic check_text(input string name, input string txt);
      int bad;
      bad = 0;
      for (int k = 0; k < txt.len(); k++) if (dec_mem[k] !== txt[k]) bad++;
      check(name, bad, 0);
   endtask

   task automatic run_full(input string name);
      int cnt, nproc, nmis, touched;
      prep();
      for (int k = 0; k < exp_n; k++) sb.push_back('{a: AW'(k), d: exp_dec[k]});
      @(negedge clk);
      start_decrypt = 1'b1;
      @(posedge clk);
      cnt = 1;
      while (1) begin
         @(negedge clk);
         if (done_decrypting || cnt > 2000) break;
         @(posedge clk);
         cnt++;
      end
      nproc = exp_n + (exp_abort ? 1 : 0);
      check({name, "_latency"}, cnt, 14 * nproc + 1);
      repeat (5) @(negedge clk);
      check({name, "_done_held"}, int'(done_decrypting), 1);
      check({name, "_key_invalid"}, int'(key_invalid), int'(exp_abort));
      check({name, "_sb_left"}, sb.size(), 0);
      check({name, "_s_pulses"}, s_pulses, 2 * nproc);
      check({name, "_dec_pulses"}, d_pulses, exp_n);
      check({name, "_wren_overlap"}, overlap, 0);
      nmis = 0;
      for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) nmis++;
      check({name, "_s_ram_mismatches"}, nmis, 0);
      touched = 0;
      for (int n = exp_n; n < 32; n++) if (dec_mem[n] !== 8'hEE) touched++;
      check({name, "_untouched"}, touched, 0);
      start_decrypt = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_back_idle"}, int'(done_decrypting), 0);
      check({name, "_key_invalid_hold"}, int'(key_invalid), int'(exp_abort));
      sb.delete();
   endtask

   task automatic load_ident();
      for (int n = 0; n < 256; n++) init_s[n] = 8'(n);
      for (int n = 0; n < 32; n++) init_rom[n] = 8'h00;
   endtask

   task automatic load_masked(input string txt);
      for (int n = 0; n < 256; n++) init_s[n] = 8'(255 - n);
      for (int n = 0; n < 32; n++) init_rom[n] = 8'h00;
      model(1'b0);
      for (int k = 0; k < MSG_LEN; k++) init_rom[k] = exp_dec[k] ^ txt[k];
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ct[9];
      reset = 1'b1;
      start_decrypt = 1'b0;
      for (int n = 0; n < 256; n++) s_mem[n] <= 8'h00;
      for (int n = 0; n < 32; n++) begin
         rom_mem[n] <= 8'h00;
         dec_mem[n] <= 8'hEE;
      end
      #12;
      check_outputs_zero("reset_outputs");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      load_ident();
      run_full("ident");
`ifndef RC4_ASCII_CHECK_EN
      check("ident_dec0", int'(dec_mem[0]), 8'h02);
      check("ident_dec1", int'(dec_mem[1]), 8'h05);
      check("ident_dec2", int'(dec_mem[2]), 8'h07);
`else
      check("ident_abort_k0", int'(dec_mem[0]), 8'hEE);
`endif

      ksa(24'h4B6579);
      ct[0] = 8'hBB; ct[1] = 8'hF3; ct[2] = 8'h16; ct[3] = 8'hE8; ct[4] = 8'hD9;
      ct[5] = 8'h40; ct[6] = 8'hAF; ct[7] = 8'h0A; ct[8] = 8'hD3;
      for (int n = 0; n < 32; n++) init_rom[n] = (n < 9) ? ct[n] : 8'h00;
      run_full("ksa");
`ifndef RC4_ASCII_CHECK_EN
      check_text("ksa_plaintext", "Plaintext");
      check("ksa_no_invalid", int'(key_invalid), 0);
`else
      check("ksa_invalid", int'(key_invalid), 1);
      check("ksa_no_write", int'(dec_mem[0]), 8'hEE);
`endif

      load_masked("hello wor");
      run_full("hello");
      check_text("hello_text", "hello wor");

      load_masked("abcdZfghi");
      run_full("upper");
`ifndef RC4_ASCII_CHECK_EN
      check_text("upper_text", "abcdZfghi");
`else
      check_text("upper_prefix", "abcd");
      check("upper_abort_k4", int'(dec_mem[4]), 8'hEE);
      check("upper_invalid", int'(key_invalid), 1);
`endif

      load_ident();
      prep();
      if (exp_n > 0) sb.push_back('{a: AW'(0), d: exp_dec[0]});
      @(negedge clk);
      start_decrypt = 1'b1;
      @(posedge clk);
      repeat (22) @(posedge clk);
      #1 reset = 1'b1;
      #1 check_outputs_zero("async_reset_outputs");
      start_decrypt = 1'b0;
      @(negedge clk);
      check("reset_sb_drained", sb.size(), 0);
      sb.delete();
      reset = 1'b0;
      run_full("restart");
`ifndef RC4_ASCII_CHECK_EN
      check("restart_dec2", int'(dec_mem[2]), 8'h07);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
